// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DEPTH_DEF / NREG_DEF : default queue depth and writable register count
//   PC_IDX               : destination index that is never written back
//   STAMP_W              : width of the age stamp carried by each queued write
//   req_id_e             : requester identifier (EXE, MEM)
package regfile_wb_arbiter_pkg;
  localparam int         DEPTH_DEF = 2;
  localparam int         NREG_DEF  = 15;
  localparam logic [3:0] PC_IDX    = 4'd15;
  localparam int         STAMP_W   = 3;

  typedef enum logic {REQ_EXE = 1'b0, REQ_MEM = 1'b1} req_id_e;

  // True when stamp a was issued before stamp b. Live stamps span far less
  // than half the stamp space, so the modular difference b-a identifies the
  // older one even across the wrap.
  function automatic logic stamp_older(input logic [STAMP_W-1:0] a,
                                       input logic [STAMP_W-1:0] b);
    logic [STAMP_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[STAMP_W-1];
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// wb_queue: per-requester FIFO of pending register writes.
//   clk, rst         : clock, asynchronous active-low reset
//   push, push_*     : enqueue one entry (dest, data, stamp)
//   pop              : dequeue the head entry
//   full, empty      : occupancy flags
//   head_*           : contents of the oldest entry
//   dest_mask        : one bit per register that has a valid entry queued
module wb_queue
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [3:0]         push_dest,
  input  logic [31:0]        push_data,
  input  logic [STAMP_W-1:0] push_stamp,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [3:0]         head_dest,
  output logic [31:0]        head_data,
  output logic [STAMP_W-1:0] head_stamp,
  output logic [NREG-1:0]    dest_mask
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]         dest_q  [DEPTH];
  logic [31:0]        data_q  [DEPTH];
  logic [STAMP_W-1:0] stamp_q [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PW-1:0]      rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full       = &vld;
  assign empty      = ~|vld;
  assign head_dest  = dest_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];
  assign head_stamp = stamp_q[rd_ptr];

  // At full, push and pop share a slot: the clear from the pop is overridden
  // by the set from the push, so the slot stays valid with the new entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]  <= '0;
        data_q[i]  <= '0;
        stamp_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ptr_inc(rd_ptr);
      end
      if (push) begin
        vld[wr_ptr]     <= 1'b1;
        dest_q[wr_ptr]  <= push_dest;
        data_q[wr_ptr]  <= push_data;
        stamp_q[wr_ptr] <= push_stamp;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
    end
  end

  always_comb begin
    dest_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (int'(dest_q[i]) < NREG)) dest_mask[dest_q[i]] = 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges EXE and MEM writeback requests into a single
// register-file write port.
//   clk, rst            : clock, asynchronous active-low reset
//   exe_valid/ready/dest/data : EXE-stage writeback request channel
//   mem_valid/ready/dest/data : MEM-stage writeback request channel
//   wb_en, wb_dest, wb_data   : registered register-file write port
//   pending             : per-register flag, set while a write is queued or on wb_*
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exe_valid,
  output logic            exe_ready,
  input  logic [3:0]      exe_dest,
  input  logic [31:0]     exe_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [3:0]      mem_dest,
  input  logic [31:0]     mem_data,
  output logic            wb_en,
  output logic [3:0]      wb_dest,
  output logic [31:0]     wb_data,
  output logic [NREG-1:0] pending
);
  logic               rdy_en;
  logic [STAMP_W-1:0] stamp_cnt;
  req_id_e            last_grant, grant_id;
  logic               grant_vld;

  logic               exe_push, mem_push, exe_pop, mem_pop;
  logic               exe_full, exe_empty, mem_full, mem_empty;
  logic [3:0]         exe_hd_dest, mem_hd_dest;
  logic [31:0]        exe_hd_data, mem_hd_data;
  logic [STAMP_W-1:0] exe_hd_stamp, mem_hd_stamp;
  logic [NREG-1:0]    exe_mask, mem_mask, wb_mask;

  // Ready is held low through reset and comes up on the first edge after it.
  assign exe_ready = rdy_en & ~exe_full;
  assign mem_ready = rdy_en & ~mem_full;

  // Writes to the PC index are accepted but dropped.
  assign exe_push = exe_valid & exe_ready & (exe_dest != PC_IDX);
  assign mem_push = mem_valid & mem_ready & (mem_dest != PC_IDX);

  wb_queue #(.DEPTH(DEPTH), .NREG(NREG)) u_exe_q (
    .clk(clk), .rst(rst),
    .push(exe_push), .push_dest(exe_dest), .push_data(exe_data),
    .push_stamp(stamp_cnt + STAMP_W'(mem_push)),
    .pop(exe_pop), .full(exe_full), .empty(exe_empty),
    .head_dest(exe_hd_dest), .head_data(exe_hd_data), .head_stamp(exe_hd_stamp),
    .dest_mask(exe_mask)
  );

  wb_queue #(.DEPTH(DEPTH), .NREG(NREG)) u_mem_q (
    .clk(clk), .rst(rst),
    .push(mem_push), .push_dest(mem_dest), .push_data(mem_data),
    .push_stamp(stamp_cnt),
    .pop(mem_pop), .full(mem_full), .empty(mem_empty),
    .head_dest(mem_hd_dest), .head_data(mem_hd_data), .head_stamp(mem_hd_stamp),
    .dest_mask(mem_mask)
  );

  // Same destination: age order protects write-after-write ordering.
  // Different destinations: plain round-robin.
  always_comb begin
    grant_vld = ~exe_empty | ~mem_empty;
    grant_id  = REQ_EXE;
    if (!exe_empty && !mem_empty) begin
      if (exe_hd_dest == mem_hd_dest)
        grant_id = stamp_older(mem_hd_stamp, exe_hd_stamp) ? REQ_MEM : REQ_EXE;
      else
        grant_id = (last_grant == REQ_EXE) ? REQ_MEM : REQ_EXE;
    end else if (!mem_empty) begin
      grant_id = REQ_MEM;
    end
  end

  assign exe_pop = grant_vld & (grant_id == REQ_EXE);
  assign mem_pop = grant_vld & (grant_id == REQ_MEM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en     <= 1'b0;
      stamp_cnt  <= '0;
      last_grant <= REQ_EXE;
      wb_en      <= 1'b0;
      wb_dest    <= '0;
      wb_data    <= '0;
    end else begin
      rdy_en    <= 1'b1;
      stamp_cnt <= stamp_cnt + STAMP_W'(exe_push) + STAMP_W'(mem_push);
      wb_en     <= grant_vld;
      if (grant_vld) begin
        last_grant <= grant_id;
        wb_dest    <= (grant_id == REQ_MEM) ? mem_hd_dest : exe_hd_dest;
        wb_data    <= (grant_id == REQ_MEM) ? mem_hd_data : exe_hd_data;
      end
    end
  end

  always_comb begin
    wb_mask = '0;
    if (wb_en && (int'(wb_dest) < NREG)) wb_mask[wb_dest] = 1'b1;
  end

  assign pending = exe_mask | mem_mask | wb_mask;
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the entries per requester queue.
REQ-002 Parameter NREG, default 15, SHALL set the number of writable registers (indices 0..14).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 exe_valid  in  1  EXE-stage writeback request.
REQ-007 exe_ready  out  1  EXE queue can accept.
REQ-008 exe_dest  in  4  EXE destination index.
REQ-009 exe_data  in  32  EXE result.
REQ-010 mem_valid, mem_ready, mem_dest, mem_data: same widths and meaning for the MEM stage.
REQ-011 wb_en  out  1  register-file write enable.
REQ-012 wb_dest  out  4  register-file destination index.
REQ-013 wb_data  out  32  register-file write data.
REQ-014 pending  out  NREG  bit i set while a write to register i is queued or on wb_*.

Function
REQ-015 Acceptance: a request SHALL be accepted on a rising edge where valid and ready are both 1.
REQ-016 Ready: x_ready SHALL be 1 when that queue count < DEPTH; it SHALL NOT depend on a same-cycle pop.
REQ-017 Dest 15: an accepted request with dest 15 SHALL be discarded. It SHALL NOT be enqueued, SHALL NOT consume a stamp and SHALL NOT set pending.
REQ-018 Stamps: each enqueued entry SHALL carry a 3-bit stamp from a global counter. The counter SHALL increment, mod 8, once per enqueued entry.
REQ-019 Same-cycle enqueue: when both requesters enqueue in the same cycle, MEM SHALL take the older stamp and EXE the next one.
REQ-020 Issue: each cycle at most one queue head SHALL be popped and registered onto wb_*, with wb_en=1 on the following cycle.
REQ-021 Latency: minimum acceptance-to-wb_en latency SHALL be 2 cycles (enqueue edge, then issue edge).
REQ-022 When no head is popped, wb_en SHALL be 0 and wb_dest/wb_data SHALL hold their previous values.
REQ-023 Grant with one queue non-empty: that queue SHALL be granted.
REQ-024 Grant with both non-empty and equal head dest: the head with the older stamp (wrap-aware 3-bit compare) SHALL be granted.
REQ-025 Grant with both non-empty and differing head dest: round-robin; the requester not granted last SHALL be granted.
REQ-026 last_grant SHALL update on every grant.
REQ-027 Queue ordering: each queue SHALL be FIFO. Push and pop in the same cycle SHALL be legal at any count, including full.
REQ-028 pending SHALL be combinational from the valid queue entries plus the wb_* register while wb_en=1.
REQ-029 A pending bit SHALL clear the cycle after its last wb_en cycle.

Reset
REQ-030 While rst=0, the following SHALL hold:
  - queues empty; stamp counter 0;
  - last_grant = EXE;
  - wb_en, wb_dest, wb_data all 0;
  - pending 0;
  - exe_ready and mem_ready 0.
REQ-031 Ready SHALL rise on the first clock edge after rst deasserts.
REQ-032 Reset asserted mid-operation SHALL drop all queued writes, with no wb_en pulse afterwards.

Structure
REQ-033 A shared package SHALL hold:
  - DEPTH and NREG defaults;
  - PC_IDX = 15;
  - the stamp width;
  - requester-id enum (EXE, MEM).
REQ-034 The per-requester queue SHALL be one sub-module, wb_queue (DEPTH entries of dest, data, stamp), instantiated twice.

Verification
REQ-035 Single write: EXE writes dest 3 with 0x11 -> wb_en=1, dest 3, 0x11 exactly 2 cycles later; pending[3] high from the cycle after acceptance until the cycle after wb_en.
REQ-036 Simultaneous, same dest: MEM dest 5 = 0xA and EXE dest 5 = 0xB in one cycle -> wb order 0xA then 0xB on consecutive cycles.
REQ-037 Simultaneous, different dest: MEM dest 1 and EXE dest 2 -> MEM first (last_grant=EXE after reset), then EXE; a second pair alternates the same way.
REQ-038 Backpressure: 3 back-to-back EXE requests with MEM streaming -> exe_ready=0 after 2 queued; no request lost or reordered.
REQ-039 PC dest: EXE dest 15 -> no wb_en, pending unchanged, stamp counter unchanged.
REQ-040 Reset mid-stream: rst=0 with 3 entries queued -> outputs and pending 0 immediately; no wb_en after release.
